// File: rtl/posedge_detect_pkg.sv
// Shared constants and parameter checks for the rising-edge detector.
// Kept in one place so the legal synchronizer depths are defined only once.
package posedge_detect_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    // Zero means the source is already synchronous to the clock.
    // A single stage gives no metastability protection, so it is not allowed.
    function automatic bit isLegalSyncStages(input int stages);
        return (stages == 0) ||
               ((stages >= MIN_SYNC_STAGES) && (stages <= MAX_SYNC_STAGES));
    endfunction

endpackage

// File: rtl/posedge_detect_sync_ff_chain.sv
// Multi-stage flip-flop synchronizer for bringing asynchronous level signals
// into the iClk domain. Every stage clears on synchronous reset.
module sync_ff_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oData
);

    logic [WIDTH-1:0] syncStage_q [STAGES];
    logic [WIDTH-1:0] syncStage_d [STAGES];

    // Each stage takes the value of the one before it; stage 0 takes the raw input.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            syncStage_d[i] = '0;
        end
        syncStage_d[0] = iData;
        for (int i = 1; i < STAGES; i++) begin
            syncStage_d[i] = syncStage_q[i-1];
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < STAGES; i++) begin
                syncStage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                syncStage_q[i] <= syncStage_d[i];
            end
        end
    end

    assign oData = syncStage_q[STAGES-1];

endmodule

// File: rtl/posedge_detect.sv
// Per-lane rising-edge detector: one registered single-cycle pulse on oSig
// for every 0->1 transition of the (optionally synchronized) input iSig.
module posedge_detect
    import posedge_detect_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iSig,
    output logic [WIDTH-1:0] oSig
);

    logic [WIDTH-1:0] sampled;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] pulse_q;
    logic [WIDTH-1:0] pulse_d;

    generate
        if (!isLegalSyncStages(SYNC_STAGES)) begin : gIllegalSyncStages
            $error("posedge_detect: SYNC_STAGES must be 0 or 2..4");
        end

        if (SYNC_STAGES == 0) begin : gNoSync
            assign sampled = iSig;
        end else begin : gSync
            sync_ff_chain #(
                .WIDTH  (WIDTH),
                .STAGES (SYNC_STAGES)
            ) uSyncChain (
                .iClk  (iClk),
                .iRst  (iRst),
                .iData (iSig),
                .oData (sampled)
            );
        end
    endgenerate

    // A lane pulses when it is high now but was low at the previous edge.
    always_comb begin
        prev_d  = sampled;
        pulse_d = sampled & ~prev_q;
    end

    // Clearing the history on reset makes an already-high input count as a rising edge.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            prev_q  <= '0;
            pulse_q <= '0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign oSig = pulse_q;

endmodule

// File: tb/tb_posedge_detect.sv
// Self-checking bench: two 4-lane detectors (no synchronizer and a 2-stage one)
// compared every cycle against a history-based model, plus pinned literal checks.
module tb_posedge_detect;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out2;

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] sigHist [$];
    bit               rstHist [$];

    posedge_detect #(.WIDTH(WIDTH), .SYNC_STAGES(0)) dut0 (
        .iClk (clk),
        .iRst (rst),
        .iSig (sig),
        .oSig (out0)
    );

    posedge_detect #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut2 (
        .iClk (clk),
        .iRst (rst),
        .iSig (sig),
        .oSig (out2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Record exactly what the designs see at each rising edge.
    always @(posedge clk) begin
        sigHist.push_back(sig);
        rstHist.push_back(rst);
    end

    // Effective detector input at edge k: the input from `delay` edges earlier,
    // unless a reset at any of the edges in between has flushed it to zero.
    function automatic logic [WIDTH-1:0] effInput(int k, int delay);
        if (k < 0 || k - delay < 0) return '0;
        for (int j = k - delay; j < k; j++) begin
            if (rstHist[j]) return '0;
        end
        return sigHist[k - delay];
    endfunction

    // Output after edge k: rising of the effective stream; reset forces zero
    // and wipes the remembered previous value.
    function automatic logic [WIDTH-1:0] expectedOut(int k, int delay);
        logic [WIDTH-1:0] prevVal;
        if (rstHist[k]) return '0;
        prevVal = (k == 0 || rstHist[k-1]) ? '0 : effInput(k - 1, delay);
        return effInput(k, delay) & ~prevVal;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, once at least one edge has happened, both outputs follow the model.
    always @(negedge clk) begin
        if (sigHist.size() > 0) begin
            checkOutput("model_sync0", out0, expectedOut(sigHist.size() - 1, 0));
            checkOutput("model_sync2", out2, expectedOut(sigHist.size() - 1, 2));
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] s, input logic r);
        @(negedge clk);
        sig = s;
        rst = r;
    endtask

    // Drive one cycle and pin both outputs to hand-computed values after the edge.
    task automatic stepAndPin(input string name, input logic [WIDTH-1:0] s, input logic r,
                              input logic [WIDTH-1:0] exp0, input logic [WIDTH-1:0] exp2);
        applyStimulus(s, r);
        @(posedge clk);
        #1;
        checkOutput({name, "_s0"}, out0, exp0);
        checkOutput({name, "_s2"}, out2, exp2);
    endtask

    initial begin
        logic [WIDTH-1:0] level;
        rst = 1'b1;
        sig = '0;

        stepAndPin("rst_hold_a", 4'hF, 1'b1, 4'h0, 4'h0);
        stepAndPin("rst_hold_b", 4'h0, 1'b1, 4'h0, 4'h0);
        stepAndPin("rst_hold_c", 4'hF, 1'b1, 4'h0, 4'h0);

        stepAndPin("imm_high_a", 4'hF, 1'b0, 4'hF, 4'h0);
        stepAndPin("imm_high_b", 4'hF, 1'b0, 4'h0, 4'h0);
        stepAndPin("imm_high_c", 4'hF, 1'b0, 4'h0, 4'hF);
        stepAndPin("imm_high_d", 4'hF, 1'b0, 4'h0, 4'h0);

        stepAndPin("fall_a", 4'h0, 1'b0, 4'h0, 4'h0);
        stepAndPin("fall_b", 4'h0, 1'b0, 4'h0, 4'h0);
        stepAndPin("fall_c", 4'h0, 1'b0, 4'h0, 4'h0);

        stepAndPin("alt_a", 4'h1, 1'b0, 4'h1, 4'h0);
        stepAndPin("alt_b", 4'h0, 1'b0, 4'h0, 4'h0);
        stepAndPin("alt_c", 4'h1, 1'b0, 4'h1, 4'h1);
        stepAndPin("alt_d", 4'h0, 1'b0, 4'h0, 4'h0);
        stepAndPin("alt_e", 4'h0, 1'b0, 4'h0, 4'h1);
        stepAndPin("alt_f", 4'h0, 1'b0, 4'h0, 4'h0);

        stepAndPin("lanes_a", 4'h5, 1'b0, 4'h5, 4'h0);
        stepAndPin("lanes_b", 4'h5, 1'b0, 4'h0, 4'h0);
        stepAndPin("lanes_c", 4'h5, 1'b0, 4'h0, 4'h5);
        stepAndPin("lanes_d", 4'h5, 1'b0, 4'h0, 4'h0);

        stepAndPin("midpulse_a", 4'h0, 1'b0, 4'h0, 4'h0);
        stepAndPin("midpulse_b", 4'h8, 1'b0, 4'h8, 4'h0);
        stepAndPin("midpulse_c", 4'h8, 1'b1, 4'h0, 4'h0);

        // Half-cycle glitch inside reset, not straddling a rising edge.
        @(negedge clk);
        sig = '0;
        rst = 1'b1;
        #2 sig = 4'hF;
        #5 sig = '0;
        @(posedge clk);
        #1;
        checkOutput("glitch_in_rst_s0", out0, 4'h0);

        stepAndPin("after_rst_a", 4'h0, 1'b0, 4'h0, 4'h0);
        stepAndPin("after_rst_b", 4'h0, 1'b0, 4'h0, 4'h0);
        stepAndPin("after_rst_c", 4'h0, 1'b0, 4'h0, 4'h0);
        stepAndPin("after_rst_d", 4'h2, 1'b0, 4'h2, 4'h0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'h2, 1'b0);
        end
        stepAndPin("long_high_fall", 4'h0, 1'b0, 4'h0, 4'h0);

        // Randomised phase: levels mostly held, occasional changes and resets.
        level = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                level = WIDTH'($urandom);
            end
            applyStimulus(level, ($urandom_range(0, 15) == 0));
        end
        applyStimulus('0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
